fetch_prefetch_unit: RTL
========================

FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 SHALL have parameter NB_REG, default 32, PC/address width.
REQ-002 SHALL have parameter NB_INSTR, default 32, instruction width.
REQ-003 SHALL have parameter N_ADDR, default 2048, instruction-memory depth in words.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, prefetch-queue entries (power of 2, >=2).
REQ-005 SHALL have parameter INSTR_FILE, default "", memory init file.
REQ-006 SHALL have port i_clock  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have port i_reset  in  1  synchronous, active-low reset.
REQ-008 SHALL have port i_valid  in  1  global step enable.
REQ-009 SHALL have port i_ready  in  1  decode accepts the head entry.
REQ-010 SHALL have port i_redirect  in  1  jump/branch taken; flush and refetch.
REQ-011 SHALL have port i_redirect_pc  in  NB_REG  redirect target.
REQ-012 SHALL have port o_valid  out  1  head entry present.
REQ-013 SHALL have port o_ir  out  NB_INSTR  head instruction.
REQ-014 SHALL have port o_pc  out  NB_REG  head PC+4.

Function
REQ-015 SHALL hold a fetch PC, one-cycle-latency synchronous instruction memory (word address = PC[log2(N_ADDR)+1:2]), and a FIFO of {instr, pc+4}.
REQ-016 SHALL issue a read in a cycle when i_valid=1 and (count + inflight) < FIFO_DEPTH, inflight being 0/1; fetch PC then advances by 4, wrapping mod 2^NB_REG.
REQ-017 SHALL write a read's data into the FIFO on the cycle after issue, unless killed; in-flight data is captured even if i_valid=0.
REQ-018 SHALL drive o_valid=(count!=0), o_ir/o_pc from FIFO head combinationally; o_ir=0 when o_valid=0.
REQ-019 SHALL pop the head when o_valid=1, i_ready=1, i_valid=1; simultaneous push and pop leave count unchanged.
REQ-020 SHALL never push when full, never pop when empty, FIFO pointers wrapping modulo FIFO_DEPTH.
REQ-021 SHALL, on i_redirect=1 with i_valid=1: clear FIFO, kill the in-flight read, issue a read at {i_redirect_pc[NB_REG-1:2],2'b00} in the same cycle, and set fetch PC to that +4.
REQ-022 SHALL give redirect priority over pop in the same cycle (popped entry discarded).
REQ-023 SHALL yield latency: issue in cycle N -> o_valid=1 in cycle N+2.
REQ-024 SHALL hold all state (except in-flight capture) when i_valid=0.

Reset
REQ-025 SHALL, with i_reset=0 at a clock edge, set fetch PC=0, count=0, pointers=0, inflight=0, o_valid=0, counters=0.
REQ-026 SHALL discard any in-flight read when reset is asserted mid-operation.
REQ-027 SHALL issue first read at address 0 in the first cycle with i_reset=1 and i_valid=1.

Configuration
REQ-028 SHALL, with macro FETCH_STATS_EN defined, add outputs o_fetch_count and o_bubble_count (32 bits each, saturating at all-ones) counting pops and cycles with i_valid=1, i_ready=1, o_valid=0.
REQ-029 SHALL, without FETCH_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-030 SHALL cover reset release, i_valid=1, i_ready=1, mem[0..3]=A,B,C,D -> o_valid at cycle 2; o_ir=A,B,C,D on consecutive cycles with o_pc=4,8,12,16.
REQ-031 SHALL cover i_ready=0 for 10 cycles -> count saturates at 4, reads stop, o_ir=A held; i_ready=1 then drains A..D without loss or duplication.
REQ-032 SHALL cover i_redirect=1, i_redirect_pc=0x40 with FIFO full -> o_valid=0 next cycle, then o_ir=mem[16], o_pc=0x44 two cycles after redirect.
REQ-033 SHALL cover i_redirect_pc=0x43 -> fetch from 0x40; redirect plus pop same cycle -> popped entry not re-presented.
REQ-034 SHALL cover reset asserted with read in flight and FIFO half full -> o_valid=0; after release first o_ir=mem[0].
REQ-035 SHALL cover, with FETCH_STATS_EN, 5 pops and 3 bubble cycles -> o_fetch_count=5, o_bubble_count=3.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction fetch with a small prefetch queue.
// A fetch PC drives a one-cycle-latency synchronous instruction memory, and
// the returned words are queued as {instr, pc+4} for the decode stage.
// A redirect flushes the queue, kills the outstanding read and refetches
// from the word-aligned target.
// Optional build macro FETCH_STATS_EN adds saturating pop/bubble counters
// on the o_fetch_count / o_bubble_count outputs.
module fetch_prefetch_unit #(
  parameter int    NB_REG     = 32,
  parameter int    NB_INSTR   = 32,
  parameter int    N_ADDR     = 2048,
  parameter int    FIFO_DEPTH = 4,
  parameter string INSTR_FILE = ""
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic                i_ready,
  input  logic                i_redirect,
  input  logic [NB_REG-1:0]   i_redirect_pc,
  output logic                o_valid,
  output logic [NB_INSTR-1:0] o_ir,
  output logic [NB_REG-1:0]   o_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]         o_fetch_count,
  output logic [31:0]         o_bubble_count
`endif
);

  localparam int AW = $clog2(N_ADDR);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Instruction memory
  logic [NB_INSTR-1:0] mem [N_ADDR] = '{default: '0};

  // Architectural state
  logic [NB_REG-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                inflight_q, inflight_d;
  logic [NB_REG-1:0]   inflight_pc_q, inflight_pc_d;
  logic [NB_INSTR-1:0] rdata_q;
  logic [NB_INSTR-1:0] fifo_ir_q [FIFO_DEPTH];
  logic [NB_REG-1:0]   fifo_pc_q [FIFO_DEPTH];

  // Per-cycle control
  logic                redirect;
  logic                issue;
  logic                push;
  logic                pop;
  logic [NB_REG-1:0]   issue_pc;
  logic [NB_REG-1:0]   redirect_target;
  logic [CW-1:0]       occupancy;
  logic [AW-1:0]       mem_addr;

  assign redirect        = i_valid & i_redirect;
  assign redirect_target = i_redirect_pc & ~NB_REG'(3);
  assign occupancy       = count_q + CW'(inflight_q);
  assign o_valid         = (count_q != '0);
  assign o_ir            = o_valid ? fifo_ir_q[rd_ptr_q] : '0;
  assign o_pc            = fifo_pc_q[rd_ptr_q];

  // Decide issue/push/pop and compute the next queue and fetch state
  always_comb begin
    issue         = 1'b0;
    issue_pc      = fetch_pc_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    // An outstanding read lands even when the pipe is stalled, unless a
    // redirect kills it in the same cycle.
    push          = inflight_q & ~redirect & (count_q != DEPTH_C);
    pop           = o_valid & i_ready & i_valid & ~redirect;

    if (redirect) begin
      issue    = 1'b1;
      issue_pc = redirect_target;
    end else if (i_valid && (occupancy < DEPTH_C)) begin
      issue    = 1'b1;
    end

    inflight_d = issue;
    if (issue) begin
      fetch_pc_d    = issue_pc + NB_REG'(4);
      inflight_pc_d = issue_pc + NB_REG'(4);
    end

    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  assign mem_addr = AW'(issue_pc >> 2);

  // Register fetch PC, queue pointers, occupancy and the in-flight tag
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      fetch_pc_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // Synchronous memory read port; data is valid the cycle after issue
  always_ff @(posedge i_clock) begin
    if (issue) rdata_q <= mem[mem_addr];
  end

  // Queue storage write; the pointers alone decide what is live
  always_ff @(posedge i_clock) begin
    if (push && i_reset) begin
      fifo_ir_q[wr_ptr_q] <= rdata_q;
      fifo_pc_q[wr_ptr_q] <= inflight_pc_q;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;
  logic        bubble;

  assign bubble         = i_valid & i_ready & ~o_valid;
  assign o_fetch_count  = fetch_count_q;
  assign o_bubble_count = bubble_count_q;

  // Saturating counters: delivered instructions and starved decode cycles
  always_comb begin
    fetch_count_d  = fetch_count_q;
    bubble_count_d = bubble_count_q;
    if (pop && (fetch_count_q != '1))    fetch_count_d  = fetch_count_q + 32'd1;
    if (bubble && (bubble_count_q != '1)) bubble_count_d = bubble_count_q + 32'd1;
  end

  // Register the statistics counters
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end
`endif

endmodule
